// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: fills an input frame, runs the parallel FFT for its fixed latency, then drains the bins.
// Define FFT_FRAME_CTRL_BITREV_EN to drain the output bins in bit-reversed order.
module fft_frame_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int N           = 16,
    parameter int FFT_LATENCY = $clog2(N) + 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic signed [DATA_WIDTH-1:0]       s_real,
    input  logic signed [DATA_WIDTH-1:0]       s_imag,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic signed [DATA_WIDTH-1:0]       m_real,
    output logic signed [DATA_WIDTH-1:0]       m_imag,
    output logic [$clog2(N)-1:0]               m_index,
    output logic                               m_last,
    output logic [N-1:0][DATA_WIDTH-1:0]       fft_real_in,
    output logic [N-1:0][DATA_WIDTH-1:0]       fft_imag_in,
    input  logic [N-1:0][DATA_WIDTH-1:0]       fft_real_out,
    input  logic [N-1:0][DATA_WIDTH-1:0]       fft_imag_out,
    output logic                               busy,
    output logic                               frame_done
);
    localparam int AW = $clog2(N);
    localparam int LW = $clog2(FFT_LATENCY + 1);
    typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;
    state_t r_state, w_next;
    logic [AW-1:0] r_wr_cnt, r_rd_cnt, w_rd_idx;
    logic [LW-1:0] r_lat_cnt;
    logic [N-1:0][DATA_WIDTH-1:0] r_in_real, r_in_imag, r_out_real, r_out_imag;
    logic r_s_ready, r_frame_done, w_wr, w_rd, w_wr_last, w_lat_done;
    assign w_wr       = s_valid && r_s_ready && r_state == FILL;
    assign w_wr_last  = w_wr && r_wr_cnt == AW'(N - 1);
    assign w_rd       = r_state == DRAIN && m_ready;
    assign w_lat_done = r_state == RUN && r_lat_cnt == LW'(FFT_LATENCY);
`ifdef FFT_FRAME_CTRL_BITREV_EN
    always_comb begin
        w_rd_idx = '0;
        for (int i = 0; i < AW; i++) w_rd_idx[i] = r_rd_cnt[AW-1-i];
    end
`else
    assign w_rd_idx = r_rd_cnt;
`endif
    assign s_ready     = r_s_ready;
    assign m_valid     = r_state == DRAIN;
    assign m_real      = r_out_real[w_rd_idx];
    assign m_imag      = r_out_imag[w_rd_idx];
    assign m_index     = r_rd_cnt;
    assign m_last      = m_valid && r_rd_cnt == AW'(N - 1);
    assign busy        = r_wr_cnt != '0 || r_state != FILL;
    assign frame_done  = r_frame_done;
    assign fft_real_in = r_in_real;
    assign fft_imag_in = r_in_imag;
    always_comb begin
        w_next = r_state;
        case (r_state)
            FILL:    w_next = w_wr_last ? RUN : FILL;
            RUN:     w_next = w_lat_done ? DRAIN : RUN;
            DRAIN:   w_next = (w_rd && m_last) ? FILL : DRAIN;
            default: w_next = FILL;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FILL;
        else        r_state <= w_next;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_ready    <= 1'b0;
            r_frame_done <= 1'b0;
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_lat_cnt    <= '0;
            r_in_real    <= '0;
            r_in_imag    <= '0;
            r_out_real   <= '0;
            r_out_imag   <= '0;
        end else begin
            r_s_ready    <= w_next == FILL;
            r_frame_done <= w_rd && m_last;
            if (w_wr) begin
                r_in_real[r_wr_cnt] <= s_real;
                r_in_imag[r_wr_cnt] <= s_imag;
            end
            // wr_cnt parks at N-1 until the frame completes so busy stays meaningful
            r_wr_cnt  <= (w_rd && m_last) ? '0 : (w_wr && !w_wr_last) ? r_wr_cnt + 1'b1 : r_wr_cnt;
            r_rd_cnt  <= w_rd ? (m_last ? '0 : r_rd_cnt + 1'b1) : r_rd_cnt;
            r_lat_cnt <= (r_state == RUN && !w_lat_done) ? r_lat_cnt + 1'b1 : '0;
            if (w_lat_done) begin
                r_out_real <= fft_real_out;
                r_out_imag <= fft_imag_out;
            end
        end
    end
endmodule
